// File: rtl/dat_read_buffer.sv
`timescale 1ns / 1ps
// One-block receive buffer between the SD DAT receiver and the host Buffer Data Port.
// Starts the receiver per block, holds the block until the host drains it, gates SD clock meanwhile.
module dat_read_buffer #(
    parameter int unsigned MaxBlockBitSize = 10,
    parameter int unsigned BlockCountWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sd_clk_en_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    input  logic [BlockCountWidth-1:0] block_count_i,
    output logic                       rx_start_o,
    input  logic                       rx_valid_i,
    input  logic [31:0]                rx_data_i,
    input  logic                       rx_done_i,
    input  logic                       rx_crc_err_i,
    input  logic                       rx_end_bit_err_i,
    output logic [31:0]                buf_rdata_o,
    input  logic                       buf_rd_en_i,
    output logic                       buf_read_ready_o,
    output logic                       sd_clk_stop_o,
    output logic                       xfer_done_o,
    output logic                       crc_err_o,
    output logic                       end_bit_err_o
);

    localparam int unsigned PtrW  = MaxBlockBitSize - 2;
    localparam int unsigned Depth = 2 ** PtrW;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StReceive,
        StHostRead
    } state_e;

    state_e                     state_q;
    logic [PtrW-1:0]            wr_ptr_q;
    logic [PtrW-1:0]            rd_ptr_q;
    logic [PtrW-1:0]            last_idx_q;
    logic                       wr_full_q;
    logic [BlockCountWidth-1:0] count_q;
    logic [31:0]                mem [Depth];

    logic [MaxBlockBitSize-1:0] size_m1;
    logic                       unused_size;
    logic                       wr_en;
    logic                       pop;
    logic                       pop_last;
    logic                       rx_err;
    logic                       err_done;

    // Index of the last word: ceil(size/4)-1 == floor((size-1)/4) for size >= 1.
    assign size_m1     = block_size_i - MaxBlockBitSize'(1);
    assign unused_size = ^size_m1[1:0];

    assign rx_err   = rx_crc_err_i | rx_end_bit_err_i;
    assign wr_en    = (state_q == StReceive) && rx_valid_i && !wr_full_q && !abort_i;
    assign pop      = (state_q == StHostRead) && buf_rd_en_i && !abort_i;
    assign pop_last = pop && (rd_ptr_q == last_idx_q);
    assign err_done = (state_q == StReceive) && rx_done_i && rx_err && !abort_i;

    assign rx_start_o       = (state_q == StStart);
    assign buf_read_ready_o = (state_q == StHostRead);
    assign buf_rdata_o      = (state_q == StHostRead) ? mem[rd_ptr_q] : 32'h0;
    assign sd_clk_stop_o    = (state_q == StHostRead) && (count_q > BlockCountWidth'(1));
    assign xfer_done_o      = err_done || (pop_last && (count_q == BlockCountWidth'(1)));
    assign crc_err_o        = err_done & rx_crc_err_i;
    assign end_bit_err_o    = err_done & rx_end_bit_err_i;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_idx_q <= '0;
            wr_full_q  <= 1'b0;
            count_q    <= '0;
        end else if (abort_i) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_full_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        last_idx_q <= size_m1[MaxBlockBitSize-1:2];
                        count_q    <= (block_count_i == '0) ? BlockCountWidth'(1) : block_count_i;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        wr_full_q  <= 1'b0;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (sd_clk_en_i) begin
                        state_q <= StReceive;
                    end
                end
                StReceive: begin
                    // Full flag rather than pointer compare so a max-size block never wraps.
                    if (wr_en) begin
                        if (wr_ptr_q == last_idx_q) begin
                            wr_full_q <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PtrW'(1);
                        end
                    end
                    if (rx_done_i) begin
                        wr_ptr_q  <= '0;
                        wr_full_q <= 1'b0;
                        rd_ptr_q  <= '0;
                        state_q   <= rx_err ? StIdle : StHostRead;
                    end
                end
                StHostRead: begin
                    if (pop) begin
                        if (pop_last) begin
                            rd_ptr_q <= '0;
                            count_q  <= count_q - BlockCountWidth'(1);
                            state_q  <= (count_q == BlockCountWidth'(1)) ? StIdle : StStart;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PtrW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
